writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Write-side initiator for the 32x32 GPR file; drives the file's write port (write address, write data, write enable).
- Arbitrates two result sources: single-cycle ALU results (no backpressure) and multi-cycle load results (valid/ready handshake, buffered in a FIFO).
- Keeps a per-register pending scoreboard and raises a combinational issue stall on RAW/WAW hazards against in-flight writes.

Parameters:
- MEM_FIFO_DEPTH, 4, load-result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  instruction presented for issue
- iss_rs  in  5  source register 1 of the issuing instruction
- iss_rt  in  5  source register 2 of the issuing instruction
- iss_rd  in  5  destination register; 0 means no destination
- iss_stall  out  1  combinational; instruction must hold
- alu_valid  in  1  ALU result valid this cycle; must be accepted
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when mem_valid and mem_ready are both high
- mem_rd  in  5  load destination register
- mem_data  in  32  load result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)

Behaviour:
- Reset (applies at any time, including mid-operation):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - All pending bits cleared; FIFO emptied; mem_ready=1 in the first cycle after reset.
  - In-flight results are dropped.
- Scoreboard:
  - pending[31:0]; pending[0] is always 0.
  - iss_stall = iss_valid && (pending[iss_rs] | pending[iss_rt] | (iss_rd!=0 && pending[iss_rd])).
  - Issue is accepted when iss_valid && !iss_stall. On acceptance with iss_rd!=0, pending[iss_rd] is set at the clock edge.
- Load FIFO:
  - mem_ready = !full. A handshake pushes the pair {mem_rd, mem_data}.
  - Simultaneous push and pop while full is not permitted, because ready is already low.
  - Push and pop in the same cycle when not full: occupancy is unchanged.
  - Read and write pointers wrap modulo MEM_FIFO_DEPTH.
- Arbitration (each cycle):
  - If alu_valid: select the ALU result. The ALU always wins; the FIFO head waits.
  - Else if the FIFO is not empty: select the FIFO head and pop it.
  - Else: no selection.
  - Load starvation under continuous ALU traffic is permitted; the pipeline guarantees idle slots.
- Output register (latency 1):
  - At edge N the selected result is registered. rf_we=1 in cycle N+1 if the selected rd!=0; else rf_we=0.
  - rf_waddr and rf_wdata update on every selection; they hold their previous value when nothing is selected.
  - pending[rd] is cleared at the same edge N. In cycle N+1 a dependent instruction is therefore unstalled, and the register file's same-cycle write forwarding supplies the value.
- Same-edge set and clear of the same register: set wins, so the bit stays pending for the newer producer.
- Results with rd=0 are discarded: no write, no scoreboard change. Any FIFO entry with rd=0 is still popped.
- A writeback to a register that is not pending is legal: it writes and the bit stays 0.

Optional Feature:
- WB_PERF_CNT_EN defined:
  - Adds output perf_stall_cnt, 32 bits: increments each cycle iss_valid && iss_stall.
  - Adds output perf_memwait_cnt, 32 bits: increments each cycle the FIFO is non-empty while alu_valid=1.
  - Both counters wrap at 2^32 and clear on rst.
- Undefined: neither port nor either counter exists.

Test Plan:
- Reset hold for 2 cycles, then idle -> rf_we=0, mem_ready=1, iss_stall=0 for iss_valid=1 with rs=rt=rd=0.
- Issue rd=5 (accepted); next cycle issue rs=5 -> iss_stall=1. Then alu_valid, rd=5, data=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, and iss_stall=0 in that same cycle.
- Handshake a load (rd=7, data=0xAAAA) in the same cycle as alu_valid (rd=3, data=0x55) -> cycle+1: write to 3 with 0x55; cycle+2: write to 7 with 0xAAAA.
- Hold alu_valid=1 for 6 cycles while offering 5 loads with depth 4 -> mem_ready=0 after 4 pushes; after the ALU stops, the loads drain in push order, one per cycle.
- alu_valid with rd=0, data=0xFFFFFFFF -> rf_we stays 0; the scoreboard is unchanged.
- Same edge: issue rd=9 accepted while a writeback to rd=9 is selected -> pending[9] remains 1; a following issue with rs=9 stalls.

Source files
------------

// File: rtl/writeback_unit.sv
// GPR write-port initiator: ALU/load arbitration, load FIFO, pending-register scoreboard.
// Define WB_PERF_CNT_EN to add the stall and load-wait performance counters.

// Load-result buffer: 0-cycle head visibility, push refused while full (ready = !full).
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            mem[wptr[AW-1:0]] <= push_data;
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
      end
   end
endmodule

// ALU beats loads every cycle; selected result reaches the register file one cycle later.
module writeback_unit #(
   parameter int MEM_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rs,
   input  logic [4:0]  iss_rt,
   input  logic [4:0]  iss_rd,
   output logic        iss_stall,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
`ifdef WB_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_memwait_cnt
`endif
);
   logic [31:0] pending;
   logic [31:0] pending_nxt;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [36:0] fifo_head;
   logic        sel_valid;
   logic [4:0]  sel_rd;
   logic [31:0] sel_data;

   assign iss_stall = iss_valid && (pending[iss_rs] || pending[iss_rt] ||
                                    (iss_rd != 5'd0 && pending[iss_rd]));

   assign mem_ready = !fifo_full;
   assign fifo_push = mem_valid && !fifo_full;
   assign fifo_pop  = !alu_valid && !fifo_empty;

   wb_fifo #(.WIDTH(37), .DEPTH(MEM_FIFO_DEPTH)) u_load_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({mem_rd, mem_data}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = 5'd0;
      sel_data  = 32'd0;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel_rd    = fifo_head[36:32];
         sel_data  = fifo_head[31:0];
      end
   end

   // Set after clear so a newly issued producer keeps the bit over an older writeback.
   always_comb begin
      pending_nxt = pending;
      if (sel_valid && sel_rd != 5'd0)
         pending_nxt[sel_rd] = 1'b0;
      if (iss_valid && !iss_stall && iss_rd != 5'd0)
         pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= 5'd0;
         rf_wdata <= 32'd0;
      end else begin
         pending <= pending_nxt;
         rf_we   <= sel_valid && (sel_rd != 5'd0);
         if (sel_valid) begin
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
         end
      end
   end

`ifdef WB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt   <= 32'd0;
         perf_memwait_cnt <= 32'd0;
      end else begin
         if (iss_valid && iss_stall)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (alu_valid && !fifo_empty)
            perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
      end
   end
`else
   // No performance counters in this build.
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit; expected writes go through a scoreboard queue.
module tb_writeback_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rs;
   logic [4:0]  iss_rt;
   logic [4:0]  iss_rd;
   logic        iss_stall;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int total = 0;
   int bad   = 0;
   logic [36:0] expq[$];

   writeback_unit #(.MEM_FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rs    (iss_rs),
      .iss_rt    (iss_rt),
      .iss_rd    (iss_rd),
      .iss_stall (iss_stall),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      expq.push_back({rd, data});
   endtask

   // Every register-file write must match the oldest outstanding expectation.
   task automatic monitor;
      logic [36:0] e;
      forever begin
         @(negedge clk);
         if (rf_we === 1'b1) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected actual=%0d/%h required=none", rf_waddr, rf_wdata);
            end else begin
               e = expq.pop_front();
               chk("sb_waddr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
               chk("sb_wdata", rf_wdata, e[31:0]);
            end
         end
      end
   endtask

   initial begin
      int k;
      rst = 1'b1;
      iss_valid = 1'b0; iss_rs = '0; iss_rt = '0; iss_rd = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      fork
         monitor();
      join_none

      // Reset state
      tick; tick;
      rst = 1'b0;
      chk("rst_we", {31'd0, rf_we}, 32'd0);
      chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_ready", {31'd0, mem_ready}, 32'd1);
      iss_valid = 1'b1;
      #1 chk("rst_stall", {31'd0, iss_stall}, 32'd0);
      tick;

      // RAW stall and release in the writeback cycle
      iss_rd = 5'd5;
      #1 chk("iss5_stall", {31'd0, iss_stall}, 32'd0);
      tick;
      iss_rd = 5'd0; iss_rs = 5'd5;
      #1 chk("raw5_stall", {31'd0, iss_stall}, 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      expect_wr(5'd5, 32'h1234);
      tick;
      alu_valid = 1'b0;
      #1;
      chk("wb5_we", {31'd0, rf_we}, 32'd1);
      chk("wb5_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("wb5_wdata", rf_wdata, 32'h1234);
      chk("wb5_unstall", {31'd0, iss_stall}, 32'd0);
      iss_valid = 1'b0; iss_rs = 5'd0;

      // ALU and load in the same cycle: ALU first, load next
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55;
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hAAAA;
      expect_wr(5'd3, 32'h55);
      expect_wr(5'd7, 32'hAAAA);
      #1 chk("t3_ready", {31'd0, mem_ready}, 32'd1);
      tick;
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("t3a_we", {31'd0, rf_we}, 32'd1);
      chk("t3a_waddr", {27'd0, rf_waddr}, 32'd3);
      chk("t3a_wdata", rf_wdata, 32'h55);
      tick;
      chk("t3b_we", {31'd0, rf_we}, 32'd1);
      chk("t3b_waddr", {27'd0, rf_waddr}, 32'd7);
      chk("t3b_wdata", rf_wdata, 32'hAAAA);
      tick;
      chk("t3_idle_we", {31'd0, rf_we}, 32'd0);
      chk("t3_hold_waddr", {27'd0, rf_waddr}, 32'd7);

      // FIFO fills behind continuous ALU traffic, then drains in order
      k = 0;
      for (int i = 0; i < 6; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
         expect_wr(alu_rd, alu_data);
         mem_valid = (k < 5); mem_rd = 5'(20 + k); mem_data = 32'hB000 + 32'(k);
         #1 chk("t4_ready", {31'd0, mem_ready}, (k < 4) ? 32'd1 : 32'd0);
         if (mem_valid && mem_ready) k++;
         tick;
      end
      alu_valid = 1'b0;
      for (int n = 0; n < 5; n++) expect_wr(5'(20 + n), 32'hB000 + 32'(n));
      for (int c = 0; c < 5; c++) begin
         mem_valid = (k < 5); mem_rd = 5'(20 + k); mem_data = 32'hB000 + 32'(k);
         #1;
         if (mem_valid && mem_ready) k++;
         tick;
         chk("t4_drain_we", {31'd0, rf_we}, 32'd1);
         chk("t4_drain_waddr", {27'd0, rf_waddr}, 32'(20 + c));
         chk("t4_drain_wdata", rf_wdata, 32'hB000 + 32'(c));
      end
      mem_valid = 1'b0;
      chk("t4_loads_taken", 32'(k), 32'd5);

      // rd=0 result: no write, scoreboard untouched
      iss_valid = 1'b1; iss_rd = 5'd12;
      tick;
      iss_rd = 5'd0; iss_rs = 5'd12;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      tick;
      alu_valid = 1'b0;
      #1;
      chk("t5_we", {31'd0, rf_we}, 32'd0);
      chk("t5_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("t5_still_pending", {31'd0, iss_stall}, 32'd1);
      iss_rs = 5'd13;
      #1 chk("t5_other_free", {31'd0, iss_stall}, 32'd0);
      iss_valid = 1'b0; iss_rs = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
      expect_wr(5'd12, 32'hC);
      tick;
      alu_valid = 1'b0;

      // Same-edge set and clear of r9: set wins
      iss_valid = 1'b1; iss_rd = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      expect_wr(5'd9, 32'h99);
      #1 chk("t6_issue", {31'd0, iss_stall}, 32'd0);
      tick;
      alu_valid = 1'b0; iss_rd = 5'd0; iss_rs = 5'd9;
      #1;
      chk("t6_we", {31'd0, rf_we}, 32'd1);
      chk("t6_set_wins", {31'd0, iss_stall}, 32'd1);
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9A;
      expect_wr(5'd9, 32'h9A);
      tick;
      alu_valid = 1'b0;
      #1 chk("t6_release", {31'd0, iss_stall}, 32'd0);
      iss_valid = 1'b0; iss_rs = 5'd0;

      // Reset mid-operation drops the buffered load and pending bits
      iss_valid = 1'b1; iss_rd = 5'd16;
      alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h1;
      mem_valid = 1'b1; mem_rd = 5'd15; mem_data = 32'h2;
      expect_wr(5'd14, 32'h1);
      tick;
      iss_valid = 1'b0; iss_rd = 5'd0; alu_valid = 1'b0; mem_valid = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t7_we", {31'd0, rf_we}, 32'd0);
      chk("t7_wdata", rf_wdata, 32'd0);
      chk("t7_ready", {31'd0, mem_ready}, 32'd1);
      iss_valid = 1'b1; iss_rs = 5'd16;
      #1 chk("t7_pending_clr", {31'd0, iss_stall}, 32'd0);
      iss_valid = 1'b0; iss_rs = 5'd0;
      repeat (4) tick;
      chk("sb_drained", 32'(expq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
